// File: rtl/me_search_ctrl.sv
// Integer-pel full-search sequencer: raster-steps candidate MVs into the SAD tree and
// replays them PIPE_LAT cycles later as compare enables; ref_ready stalls issue only.
module me_search_ctrl #(
  parameter int SR       = 16,
  parameter int MV_W     = 7,
  parameter int PIPE_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            ref_ready,
  output logic            cand_valid,
  output logic [MV_W-1:0] cand_mv_x,
  output logic [MV_W-1:0] cand_mv_y,
  output logic            cmp_clr,
  output logic            cmp_en,
  output logic [MV_W-1:0] cmp_mv_x,
  output logic [MV_W-1:0] cmp_mv_y,
  output logic            busy,
  output logic            done
);

  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-SR);
  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(SR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SEARCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [MV_W-1:0] mv_x, mv_y;
  logic                   issue, last_issue, pending;

  logic [PIPE_LAT-1:0]    dl_vld;
  logic [MV_W-1:0]        dl_x [PIPE_LAT];
  logic [MV_W-1:0]        dl_y [PIPE_LAT];

  assign issue      = (state == S_SEARCH) && ref_ready;
  assign last_issue = issue && (mv_x == MV_MAX) && (mv_y == MV_MAX);

  // The final stage is already on the compare inputs; only earlier stages keep DRAIN alive.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      pending = pending | dl_vld[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_SEARCH;
      S_SEARCH: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN:  if (!pending) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_comb begin
    cand_valid = issue;
    cmp_clr    = (state == S_CLEAR);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    cand_mv_x  = mv_x;
    cand_mv_y  = mv_y;
    cmp_en     = dl_vld[PIPE_LAT-1];
    cmp_mv_x   = dl_x[PIPE_LAT-1];
    cmp_mv_y   = dl_y[PIPE_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv_x <= '0;
      mv_y <= '0;
    end else if (state == S_CLEAR) begin
      mv_x <= MV_MIN;
      mv_y <= MV_MIN;
    end else if (issue) begin
      if (mv_x == MV_MAX) begin
        mv_x <= MV_MIN;
        mv_y <= mv_y + MV_W'(1);
      end else begin
        mv_x <= mv_x + MV_W'(1);
      end
    end
  end

  // Shifts every cycle regardless of ref_ready so compare timing never slips.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_x[i] <= '0;
        dl_y[i] <= '0;
      end
    end else begin
      dl_vld[0] <= issue && !abort;
      dl_x[0]   <= mv_x;
      dl_y[0]   <= mv_y;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1] && !abort;
        dl_x[i]   <= dl_x[i-1];
        dl_y[i]   <= dl_y[i-1];
      end
    end
  end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Scoreboarded random/directed bench for me_search_ctrl (SR=16 and SR=2 instances).
module tb_me_search_ctrl;

  localparam int PL  = 4;
  localparam int BIG = 1 << 30;

  typedef struct {
    int c;
    int x;
    int y;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ref_ready = 1'b1;
  logic sel = 1'b0;
  logic start_a, start_b;

  logic       a_cv, a_clr, a_en, a_busy, a_done;
  logic [6:0] a_cx, a_cy, a_mx, a_my;
  logic       b_cv, b_clr, b_en, b_busy, b_done;
  logic [6:0] b_cx, b_cy, b_mx, b_my;
  logic       m_cv, m_clr, m_en, m_busy, m_done;
  logic [6:0] m_cx, m_cy, m_mx, m_my;

  ev_t q_iss[$], q_cmp[$], q_clr[$], q_done[$];
  int  checks = 0, failures = 0;
  int  cyc = 0;
  int  busy_lo = 0, busy_hi = -1;
  int  plan_end = 0, last_done = -1;
  int  rmode = 0, rbase = 0;
  bit  rnd_bits [8192];
  bit  mon_en = 1'b0;

  assign start_a = start && !sel;
  assign start_b = start && sel;

  me_search_ctrl #(.SR(16), .MV_W(7), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .ref_ready(ref_ready),
    .cand_valid(a_cv), .cand_mv_x(a_cx), .cand_mv_y(a_cy), .cmp_clr(a_clr),
    .cmp_en(a_en), .cmp_mv_x(a_mx), .cmp_mv_y(a_my), .busy(a_busy), .done(a_done)
  );

  me_search_ctrl #(.SR(2), .MV_W(7), .PIPE_LAT(PL)) dut2 (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .ref_ready(ref_ready),
    .cand_valid(b_cv), .cand_mv_x(b_cx), .cand_mv_y(b_cy), .cmp_clr(b_clr),
    .cmp_en(b_en), .cmp_mv_x(b_mx), .cmp_mv_y(b_my), .busy(b_busy), .done(b_done)
  );

  always_comb begin
    if (sel) begin
      {m_cv, m_clr, m_en, m_busy, m_done} = {b_cv, b_clr, b_en, b_busy, b_done};
      {m_cx, m_cy, m_mx, m_my}            = {b_cx, b_cy, b_mx, b_my};
    end else begin
      {m_cv, m_clr, m_en, m_busy, m_done} = {a_cv, a_clr, a_en, a_busy, a_done};
      {m_cx, m_cy, m_mx, m_my}            = {a_cx, a_cy, a_mx, a_my};
    end
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit rdy_at(input int c);
    int o;
    bit r;
    o = c - rbase;
    r = 1'b1;
    if (o >= 0) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = (o % 2 == 0);
        2:       r = (o >= 50);
        default: r = rnd_bits[o % 8192];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    ref_ready = rdy_at(cyc);
  end

  // Reference: k-th issue lands on the k-th ready cycle from s+2 with raster MV; everything
  // after cycle `cut` (abort/reset) disappears.
  task automatic plan(input int s, input int sr, input int cut);
    int  n, k, c, last;
    ev_t e;
    n = 4 * sr * sr;
    k = 0;
    c = s + 2;
    last = c;
    e = '{c: s + 1, x: 0, y: 0};
    if (e.c <= cut) q_clr.push_back(e);
    while (k < n && c < s + 20000) begin
      if (rdy_at(c)) begin
        e = '{c: c, x: -sr + k % (2 * sr), y: -sr + k / (2 * sr)};
        if (e.c <= cut) q_iss.push_back(e);
        e.c = c + PL;
        if (e.c <= cut) q_cmp.push_back(e);
        k++;
        last = c;
      end
      c++;
    end
    plan_end = last + PL + 1;
    e = '{c: plan_end, x: 0, y: 0};
    if (plan_end <= cut) q_done.push_back(e);
    busy_lo = s + 1;
    busy_hi = (plan_end <= cut) ? plan_end : cut;
  endtask

  task automatic report(input string nm, input bit have, input ev_t e, input int ax, input int ay);
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s: unexpected at cyc %0d mv=(%0d,%0d), none required", nm, cyc, ax, ay);
    end else if (e.c != cyc || e.x != ax || e.y != ay) begin
      failures++;
      $display("FAIL %s: got cyc %0d mv=(%0d,%0d), required cyc %0d mv=(%0d,%0d)",
               nm, cyc, ax, ay, e.c, e.x, e.y);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  have;
    bit  exp_busy;
    if (mon_en) begin
      if (m_cv) begin
        have = (q_iss.size() > 0);
        e = '{c: 0, x: 0, y: 0};
        if (have) e = q_iss.pop_front();
        report("issue", have, e, int'($signed(m_cx)), int'($signed(m_cy)));
      end
      if (m_en) begin
        have = (q_cmp.size() > 0);
        e = '{c: 0, x: 0, y: 0};
        if (have) e = q_cmp.pop_front();
        report("cmp_en", have, e, int'($signed(m_mx)), int'($signed(m_my)));
      end
      if (m_clr) begin
        have = (q_clr.size() > 0);
        e = '{c: 0, x: 0, y: 0};
        if (have) e = q_clr.pop_front();
        report("cmp_clr", have, e, 0, 0);
      end
      if (m_done) begin
        last_done = cyc;
        have = (q_done.size() > 0);
        e = '{c: 0, x: 0, y: 0};
        if (have) e = q_done.pop_front();
        report("done", have, e, 0, 0);
      end
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      checks++;
      if (m_busy !== exp_busy) begin
        failures++;
        $display("FAIL busy: cyc %0d got %0b required %0b", cyc, m_busy, exp_busy);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start(input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #2;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
  endtask

  task automatic drain_check(input string nm);
    checks++;
    if (q_iss.size() + q_cmp.size() + q_clr.size() + q_done.size() != 0) begin
      failures++;
      $display("FAIL %s missing events: issue=%0d cmp=%0d clr=%0d done=%0d, required all 0",
               nm, q_iss.size(), q_cmp.size(), q_clr.size(), q_done.size());
    end
    q_iss.delete(); q_cmp.delete(); q_clr.delete(); q_done.delete();
  endtask

  task automatic check_int(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic run_full(input string nm, input int sr, input int mode, input int done_off);
    int s;
    s = cyc;
    rmode = mode;
    rbase = s + 2;
    last_done = -1;
    plan(s, sr, BIG);
    pulse_start(1'b0);
    wait_until(plan_end + 4);
    drain_check(nm);
    if (done_off > 0) check_int({nm, "_done_cycle"}, last_done - s, done_off);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int s, a;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check_int("reset_outputs_a", int'({a_cv, a_clr, a_en, a_busy, a_done, a_cx, a_cy, a_mx, a_my}), 0);
    check_int("reset_outputs_b", int'({b_cv, b_clr, b_en, b_busy, b_done, b_cx, b_cy, b_mx, b_my}), 0);
    mon_en = 1'b1;
    wait_until(cyc + 2);

    run_full("basic", 16, 0, 1030);

    // Second start mid-search must be ignored.
    s = cyc; rmode = 0; rbase = s + 2; last_done = -1;
    plan(s, 16, BIG);
    pulse_start(1'b0);
    wait_until(s + 500);
    pulse_start(1'b0);
    wait_until(plan_end + 4);
    drain_check("restart_ignored");
    check_int("restart_done_cycle", last_done - s, 1030);

    // Abort at offset 300.
    s = cyc; a = s + 300; rmode = 0; rbase = s + 2; last_done = -1;
    plan(s, 16, a);
    pulse_start(1'b0);
    wait_until(a);
    pulse_abort();
    check_int("abort_busy_next", int'(m_busy), 0);
    check_int("abort_cv_next", int'(m_cv), 0);
    wait_until(s + 1040);
    drain_check("abort");
    check_int("abort_no_done", last_done, -1);
    run_full("after_abort", 16, 0, 1030);

    // Synchronous reset at offset 700.
    s = cyc; a = s + 700; rmode = 0; rbase = s + 2; last_done = -1;
    plan(s, 16, a);
    pulse_start(1'b0);
    wait_until(a);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    check_int("rst_outputs", int'({a_cv, a_clr, a_en, a_busy, a_done, a_cx, a_cy, a_mx, a_my}), 0);
    wait_until(s + 1040);
    drain_check("mid_reset");
    check_int("rst_no_done", last_done, -1);

    run_full("ready_hold50", 16, 2, 1080);

    // start with abort in IDLE: stays idle.
    busy_lo = 0; busy_hi = -1; last_done = -1;
    pulse_start(1'b1);
    wait_until(cyc + 10);
    drain_check("start_abort_idle");

    sel = 1'b1;
    run_full("sr2_toggle", 2, 1, 37);

    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 8192; i++) rnd_bits[i] = ($urandom_range(3) != 0);
      wait_until(cyc + int'($urandom_range(1, 5)));
      s = cyc; rmode = 3; rbase = s + 2; last_done = -1;
      a = ($urandom_range(2) == 0) ? s + int'($urandom_range(1, 40)) : BIG;
      plan(s, 2, a);
      pulse_start(1'b0);
      if (a != BIG) begin
        wait_until(a);
        pulse_abort();
      end
      wait_until(plan_end + 4);
      drain_check("random_sr2");
    end

    sel = 1'b0;
    for (int i = 0; i < 8192; i++) rnd_bits[i] = ($urandom_range(3) != 0);
    run_full("random_sr16", 16, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/me_search_ctrl.md
Name: me_search_ctrl

Overview:
- Sequences one integer-pel full search for the variable-block-size SAD compare stage.
- Steps candidate motion vectors in raster order over the search window and drives the SAD tree.
- Clears the running-minimum registers of the compare stage before the first candidate.
- Issues compare enables and motion vectors delayed to line up with SAD results leaving the PIPE_LAT-deep SAD pipeline, then reports completion. Sits between the top-level ME FSM and the SAD tree / compare stage.

Parameters:
- SR, 16, search range; candidate x and y each run -SR..SR-1, giving (2*SR)^2 candidates.
- MV_W, 7, width of signed two's-complement MV components; must satisfy 2^(MV_W-1) >= SR.
- PIPE_LAT, 4, cycles from a candidate being issued to its SADs being valid at the compare stage; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a search; sampled only in IDLE.
- abort  in  1  synchronous abort; overrides start.
- ref_ready  in  1  reference-pixel buffer can accept a candidate this cycle.
- cand_valid  out  1  candidate issued to the SAD tree this cycle.
- cand_mv_x  out  MV_W  signed candidate x.
- cand_mv_y  out  MV_W  signed candidate y.
- cmp_clr  out  1  one-cycle pulse; compare stage loads all minima with all-ones.
- cmp_en  out  1  SADs at the compare inputs are valid this cycle.
- cmp_mv_x  out  MV_W  x of the candidate whose SADs are at the compare inputs.
- cmp_mv_y  out  MV_W  y of the candidate whose SADs are at the compare inputs.
- busy  out  1  search in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values (rst high at a clk edge): state=IDLE, all outputs 0, MV outputs 0, delay line flushed.
- States and transitions:
  - IDLE -> CLEAR on start.
  - CLEAR (1 cycle) -> SEARCH.
  - SEARCH -> DRAIN on the cycle the last candidate issues.
  - DRAIN -> DONE when the delay line holds no valid entries.
  - DONE (1 cycle) -> IDLE.
- Abort from any state: -> IDLE next edge, delay line flushed, no done pulse.
- CLEAR: cmp_clr=1, cand_valid=0. The MV counters are loaded to x=-SR, y=-SR.
- SEARCH:
  - cand_valid = ref_ready; cand_mv reflects the counters.
  - On each issue, x increments. At x=SR-1, x wraps to -SR and y increments.
  - Issuing at x=SR-1, y=SR-1 is the last candidate.
- ref_ready low stalls issue only. The counters hold and cand_valid=0, but the delay line keeps shifting, so there are no gaps in alignment.
- Delay line: PIPE_LAT stages of {valid, mv_x, mv_y}, shifting every cycle unconditionally. cmp_en, cmp_mv_x and cmp_mv_y are the last stage. cmp_en pulses exactly PIPE_LAT cycles after the matching cand_valid.
- cand_mv_x and cand_mv_y hold their last value when cand_valid=0. They are don't-care for the bench.
- busy=1 from the CLEAR cycle through the DONE cycle inclusive. done=1 only in DONE, which is the cycle after the last cmp_en.
- start while busy is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Mid-operation reset: same as abort, with all outputs forced to reset values.
- Counters are MV_W signed. No overflow is possible given the parameter constraint.
- Exactly (2*SR)^2 cmp_en pulses occur per completed search, and none after done.

Test Plan:
- Defaults, ref_ready=1, start pulsed at cycle 0:
  - cmp_clr in cycle 1.
  - cand_valid cycles 2..1025; first MV (-16,-16), 33rd MV (-16,-15), last MV (15,15).
  - cmp_en cycles 6..1029 with cmp_mv equal to cand_mv delayed by 4.
  - done in cycle 1030; busy in cycles 1-1030.
- SR=2, ref_ready toggling 1,0,1,0…:
  - 16 issues in order (-2,-2),(-1,-2),(0,-2),(1,-2),(-2,-1)…(1,1).
  - Each cmp_en exactly 4 cycles after its issue, with no duplicates or gaps in the sequence.
  - done the cycle after the 16th cmp_en.
- start re-pulsed at cycle 500 of a running search: ignored; issue count and done cycle are identical to the first test.
- abort at cycle 300:
  - Next cycle: busy=0, cand_valid=0.
  - cmp_en never asserts again; done never asserts.
  - A new start then runs a full search correctly, with cmp_clr reasserted.
- rst held high for one cycle at cycle 700 mid-search: all outputs 0 next cycle, state IDLE, no done pulse.
- ref_ready held 0 for 50 cycles right after CLEAR:
  - No cand_valid or cmp_en for those 50 cycles.
  - Search then completes with done exactly 50 cycles later than in the first test (cycle 1080).
